// File: rtl/bitty_pkg.sv
// Shared register map, bit positions and bus FSM state type for the Bitty
// instruction-memory loader.
package bitty_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DATA   = 4'h8;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_COUNT_LSB = 2;
  localparam int ST_OVF_BIT   = 8;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Packs the STATUS register; bit 7 and bits 31:9 read as zero.
  function automatic logic [31:0] status_word(input logic       ovf,
                                              input logic [4:0] count,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] w;
    w                        = '0;
    w[ST_OVF_BIT]            = ovf;
    w[ST_COUNT_LSB +: 5]     = count;
    w[ST_FULL_BIT]           = full;
    w[ST_EMPTY_BIT]          = empty;
    return w;
  endfunction

endpackage

// File: rtl/bitty_sync_fifo.sv
// Single-clock instruction FIFO. Registered head (no fall-through), power-of-two
// depth so the pointers wrap naturally. Storage is deliberately not reset.
module bitty_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [IW-1:0]            din,
  output logic [IW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage write; flush has priority so nothing is written during a flush.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; flush overrides any same-edge push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bitty_wb_imem_loader.sv
// Wishbone slave that streams Bitty instructions into a FIFO feeding the core.
//
// state    | meaning
// BUS_IDLE | waiting for a selected stb&cyc; register side effects happen on leaving
// BUS_ACK  | one-cycle acknowledge with registered read data
module bitty_wb_imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8,
  parameter int          IW        = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [IW-1:0] instr_o,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic          run_o,
  output logic          irq_o
);

  import bitty_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_e    state;
  bus_state_e    state_nxt;
  logic          hit;
  logic          take;
  logic          wr;
  logic          rd;
  logic [3:0]    offset;
  logic          push_req;
  logic          flush;
  logic          pop;
  logic          ovf;
  logic [31:0]   rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_inputs;

  assign unused_inputs = ^{wbs_sel_i[3:2], wbs_dat_i};

  assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign take     = (state == BUS_IDLE) & hit;
  assign offset   = wbs_adr_i[3:0];
  assign wr       = take & wbs_we_i;
  assign rd       = take & ~wbs_we_i;
  assign push_req = wr & (offset == OFF_DATA) & (wbs_sel_i[1:0] == 2'b11);
  assign flush    = wr & (offset == OFF_CTRL) & wbs_dat_i[CTRL_FLUSH_BIT];

  assign instr_valid_o = ~fifo_empty & run_o;
  assign pop           = instr_valid_o & instr_ready_i;
  assign irq_o         = ovf;
  assign wbs_ack_o     = (state == BUS_ACK);

  // Bus FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= BUS_IDLE;
    else           state <= state_nxt;
  end

  // Bus FSM next state: ack lasts exactly one cycle, never back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      BUS_IDLE: if (hit) state_nxt = BUS_ACK;
      BUS_ACK:  state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  // Read mux; undefined offsets and DATA read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:   rdata[CTRL_RUN_BIT] = run_o;
      OFF_STATUS: rdata = status_word(ovf, 5'(fifo_count), fifo_full, fifo_empty);
      default:    rdata = '0;
    endcase
  end

  // Registered read data, RUN and sticky overflow, all updated on the accepting edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_dat_o <= '0;
      run_o     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      wbs_dat_o <= rd ? rdata : 32'h0;
      if (wr && offset == OFF_CTRL)   run_o <= wbs_dat_i[CTRL_RUN_BIT];
      if (wr && offset == OFF_STATUS && wbs_dat_i[ST_OVF_BIT]) ovf <= 1'b0;
      if (push_req && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  bitty_sync_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .flush (flush),
    .push  (push_req),
    .pop   (pop),
    .din   (wbs_dat_i[IW-1:0]),
    .dout  (instr_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bitty_wb_imem_loader.sv
// Scoreboard bench for the Bitty Wishbone instruction loader: bus reads and
// instruction pops are checked by a monitor against queued expectations.
module tb_bitty_wb_imem_loader;
  import bitty_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat_w = 32'h0;
  logic        ack;
  logic [31:0] dat_r;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        run;
  logic        irq;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       name;
  } wb_exp_t;

  wb_exp_t     wbq[$];
  logic [15:0] iq[$];
  wb_exp_t     mon_e;
  logic [15:0] mon_i;
  int          n_tests = 0;
  int          n_fail = 0;

  bitty_wb_imem_loader #(.BASE_ADDR(BASE), .DEPTH(8), .IW(16)) dut (
    .wb_clk_i      (clk),
    .wb_rst_n      (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat_w),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_r),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .run_o         (run),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or hands over an instruction.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (wbq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_ack: got ack=1 expected no ack");
      end else begin
        mon_e = wbq.pop_front();
        if (mon_e.is_rd) chk(mon_e.name, dat_r, mon_e.exp);
      end
    end
    if (rst_n && instr_valid && instr_ready) begin
      if (iq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pop: got instr 0x%04h expected no pop", instr);
      end else begin
        mon_i = iq.pop_front();
        chk("instr_pop", 32'(instr), 32'(mon_i));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the ack cycle.
  task automatic wb_xfer(input logic wr, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string name);
    wb_exp_t e;
    int k;
    e.is_rd = !wr; e.exp = exp; e.name = name;
    wbq.push_back(e);
    stb = 1'b1; cyc = 1'b1; we = wr; adr = BASE | {28'h0, off}; dat_w = d; sel = s;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!ack && k < 20);
    if (!ack) begin
      n_tests++; n_fail++;
      $display("FAIL %s_ack_timeout: got no ack expected ack", name);
      void'(wbq.pop_back());
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    wb_xfer(1'b1, off, d, s, 32'h0, "wr");
  endtask

  task automatic wb_rd(input logic [3:0] off, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, off, 32'h0, 4'hF, exp, name);
  endtask

  task automatic pulse_ready();
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    instr_ready = 1'b1;
    while (iq.size() != 0 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    instr_ready = 1'b0;
    if (iq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d left expected 0", iq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", dat_r, 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_rd(OFF_STATUS, 32'h0000_0001, "status_reset");
    wb_rd(OFF_CTRL, 32'h0, "ctrl_reset");

    // Two words held back while RUN=0, then released
    wb_wr(OFF_DATA, 32'h0000_1234);
    wb_wr(OFF_DATA, 32'h0000_ABCD);
    wb_rd(OFF_STATUS, 32'h0000_0008, "status_cnt2");
    chk("valid_run0", 32'(instr_valid), 0);
    iq.push_back(16'h1234);
    iq.push_back(16'hABCD);
    wb_wr(OFF_CTRL, 32'h1);
    chk("valid_run1", 32'(instr_valid), 1);
    chk("head_1234", 32'(instr), 32'h1234);
    wb_rd(OFF_CTRL, 32'h1, "ctrl_run");
    pulse_ready();
    chk("head_abcd", 32'(instr), 32'hABCD);
    pulse_ready();
    chk("valid_empty", 32'(instr_valid), 0);
    wb_rd(OFF_STATUS, 32'h0000_0001, "status_drained");

    // Overflow: 9 pushes into 8 entries with RUN=0
    wb_wr(OFF_CTRL, 32'h0);
    for (int i = 0; i < 9; i++) begin
      wb_wr(OFF_DATA, 32'h0000_0100 + 32'(i));
      if (i < 8) iq.push_back(16'h0100 + 16'(i));
    end
    wb_rd(OFF_STATUS, 32'h0000_0122, "status_ovf_full");
    chk("irq_set", 32'(irq), 1);
    wb_wr(OFF_STATUS, 32'h0000_00FF);
    chk("irq_kept", 32'(irq), 1);
    wb_wr(OFF_STATUS, 32'h0000_0100);
    chk("irq_clr", 32'(irq), 0);
    wb_rd(OFF_STATUS, 32'h0000_0022, "status_full_noovf");

    // Push while full with a same-edge pop
    wb_wr(OFF_CTRL, 32'h1);
    chk("head_0100", 32'(instr), 32'h0100);
    iq.push_back(16'h5555);
    instr_ready = 1'b1;
    fork
      wb_wr(OFF_DATA, 32'h0000_5555);
      begin @(posedge clk); #1; instr_ready = 1'b0; end
    join
    wb_rd(OFF_STATUS, 32'h0000_0022, "status_pushpop_full");
    chk("irq_pushpop", 32'(irq), 0);
    drain();
    chk("valid_after_drain", 32'(instr_valid), 0);
    wb_rd(OFF_STATUS, 32'h0000_0001, "status_empty2");

    // Byte-lane filtering, undefined offset, DATA read, foreign address
    wb_wr(OFF_CTRL, 32'h0);
    wb_wr(OFF_DATA, 32'h0000_0AAA, 4'b0011);
    wb_wr(OFF_DATA, 32'h0000_7777, 4'b1100);
    wb_rd(OFF_STATUS, 32'h0000_0004, "status_sel_ignored");
    wb_wr(4'hC, 32'hFFFF_FFFF);
    wb_rd(4'hC, 32'h0, "undef_read");
    wb_rd(OFF_DATA, 32'h0, "data_read");
    wb_rd(OFF_STATUS, 32'h0000_0004, "status_after_undef");
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("foreign_no_ack", 32'(ack), 0);
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;

    // Flush with count=3 while setting RUN
    wb_wr(OFF_DATA, 32'h0000_0BBB);
    wb_wr(OFF_DATA, 32'h0000_0CCC);
    wb_rd(OFF_STATUS, 32'h0000_000C, "status_cnt3");
    wb_wr(OFF_CTRL, 32'h3);
    wb_rd(OFF_STATUS, 32'h0000_0001, "status_flushed");
    chk("run_after_flush", 32'(run), 1);
    chk("valid_after_flush", 32'(instr_valid), 0);
    wb_rd(OFF_CTRL, 32'h1, "ctrl_flush_reads0");
    iq.push_back(16'h0DDD);
    wb_wr(OFF_DATA, 32'h0000_0DDD);
    chk("head_0ddd", 32'(instr), 32'h0DDD);
    pulse_ready();

    // Clearing RUN hides but keeps contents
    wb_wr(OFF_DATA, 32'h0000_0EEE);
    chk("valid_eee", 32'(instr_valid), 1);
    wb_wr(OFF_CTRL, 32'h0);
    chk("valid_run_cleared", 32'(instr_valid), 0);
    wb_rd(OFF_STATUS, 32'h0000_0004, "status_retained");
    wb_wr(OFF_CTRL, 32'h1);
    iq.push_back(16'h0EEE);
    pulse_ready();
    chk("valid_final", 32'(instr_valid), 0);

    // Reset during the ack cycle
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h4; sel = 4'hF;
    @(posedge clk); #1;
    chk("ack_before_rst", 32'(ack), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ack_rst_drop", 32'(ack), 0);
    chk("run_rst", 32'(run), 0);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_rd(OFF_STATUS, 32'h0000_0001, "status_retry");
    wb_rd(OFF_CTRL, 32'h0, "ctrl_retry");

    repeat (3) @(posedge clk);
    #1;
    chk("wbq_left", 32'(wbq.size()), 0);
    chk("iq_left", 32'(iq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
